// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the UART receiver FIFO.
//
// Handshake: the producer (master) holds rx_valid high while the FIFO head is
// available, and the head fields (rx_data, rx_perr, rx_ferr, rx_break) are
// stable while rx_valid is high. The head is consumed on every rising clock
// edge where rx_valid && rx_ready. rx_ready may be asserted at any time and is
// ignored while rx_valid is low. rx_overrun and rx_level are status only and
// are not part of the handshake.
interface uart_rx_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int LEVEL_W = 3
);
  logic               rx_valid;
  logic               rx_ready;
  logic [DATA_W-1:0]  rx_data;
  logic               rx_perr;
  logic               rx_ferr;
  logic               rx_break;
  logic               rx_overrun;
  logic [LEVEL_W-1:0] rx_level;

  modport master (
    output rx_valid, rx_data, rx_perr, rx_ferr, rx_break, rx_overrun, rx_level,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, rx_perr, rx_ferr, rx_break, rx_overrun, rx_level,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing/break detection
// and a first-word fall-through FIFO on the read side.
module uart_rx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  uart_rxd,
  input  logic                  uart_rx_en,
  uart_rx_fifo_if.master        rx,
  output logic [2:0]            fsm_state
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = PAYLOAD_BITS + 3;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] SAMP0    = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] SAMP1    = CW'(CPB / 2);
  localparam logic [CW-1:0] SAMP_DEC = CW'(CPB / 2 + 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(PAYLOAD_BITS);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [BW-1:0]           bit_idx;
  logic                    stop_idx;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    perr_q;
  logic                    ferr_q;
  logic                    par_q;
  logic                    samp0_q;
  logic                    samp1_q;
  logic [2:0]              sync_q;

  logic                    line;
  logic                    fall;
  logic                    vote;
  logic                    decide;
  logic                    last_stop;
  logic                    par_exp;
  logic                    ferr_now;
  logic                    brk_now;
  logic                    push;
  logic [EW-1:0]           entry;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    overrun_q;
  logic                    valid;
  logic                    pop;
  logic                    full;
  logic                    do_push;
  logic                    drop;
  logic [EW-1:0]           head;

  // Two-flop synchroniser plus one history flop for edge detection; held idle while disabled
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) sync_q <= 3'b111;
    else                        sync_q <= {sync_q[1:0], uart_rxd};
  end

  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  // Bit voting, parity expectation and the frame entry pushed at the last stop decision
  always_comb begin
    vote      = (samp0_q & samp1_q) | (samp0_q & line) | (samp1_q & line);
    decide    = (state != S_IDLE) && (cnt == SAMP_DEC);
    last_stop = (STOP_BITS == 1) || stop_idx;
    par_exp   = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
    ferr_now  = ferr_q | ~vote;
    brk_now   = ferr_now && (shift_q == '0) && ((PARITY == 0) || !par_q);
    push      = (state == S_STOP) && decide && last_stop;
    entry     = {brk_now, ferr_now, perr_q, shift_q};
  end

  // Receive FSM: bit counter, sample capture and frame assembly
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      par_q    <= 1'b0;
      samp0_q  <= 1'b1;
      samp1_q  <= 1'b1;
    end else begin
      if (state != S_IDLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == SAMP0) samp0_q <= line;
        if (cnt == SAMP1) samp1_q <= line;
      end
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr_q   <= 1'b0;
          ferr_q   <= 1'b0;
          par_q    <= 1'b0;
          if (fall) state <= S_START;
        end
        S_START: begin
          if (decide && vote)        state <= S_IDLE;
          else if (cnt == CNT_LAST)  state <= S_DATA;
        end
        S_DATA: begin
          if (decide) begin
            shift_q <= {vote, shift_q[PAYLOAD_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          if (cnt == CNT_LAST && bit_idx == BITS_ALL) begin
            bit_idx <= '0;
            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (decide) begin
            par_q  <= vote;
            perr_q <= (vote != par_exp);
          end
          if (cnt == CNT_LAST) state <= S_STOP;
        end
        S_STOP: begin
          if (decide) begin
            ferr_q <= ferr_now;
            if (last_stop) state <= ferr_now ? S_WAIT : S_IDLE;
            else           stop_idx <= 1'b1;
          end
        end
        S_WAIT: begin
          if (line) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

  assign valid   = (count != '0);
  assign full    = (count == LVL_FULL);
  assign pop     = valid && rx.rx_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem[rd_ptr];

  // FIFO storage; stale contents are harmless because the pointers are reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers, occupancy and the overrun pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun_q <= drop;
    end
  end

  assign rx.rx_valid   = valid;
  assign rx.rx_data    = valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign rx.rx_perr    = valid & head[PAYLOAD_BITS];
  assign rx.rx_ferr    = valid & head[PAYLOAD_BITS+1];
  assign rx.rx_break   = valid & head[PAYLOAD_BITS+2];
  assign rx.rx_overrun = overrun_q;
  assign rx.rx_level   = count;

endmodule
